// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker and its companion generator:
// FSM state encodings, counter widths and a saturating increment helper.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    localparam int ERR_CNT_W = 32;
    localparam int BIT_CNT_W = 48;

    // Increment that sticks at all ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bus between a PRBS source/controller (master) and prbs_checker (slave).
// Optional feature macro: PRBS_CHECKER_BITCNT_EN adds the bit_count signal.
interface prbs_checker_if
    import prbs_pkg::*;
#(
    parameter int N = 32
);
    logic [N-1:0]           mask;
    logic                   in_bit;
    logic                   in_valid;
    logic                   restart;
    logic                   clr_cnt;
    logic                   locked;
    logic                   err_pulse;
    logic                   lock_lost;
    logic [ERR_CNT_W-1:0]   err_count;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [BIT_CNT_W-1:0]   bit_count;

    modport master (
        output mask, in_bit, in_valid, restart, clr_cnt,
        input  locked, err_pulse, lock_lost, err_count, bit_count
    );

    modport slave (
        input  mask, in_bit, in_valid, restart, clr_cnt,
        output locked, err_pulse, lock_lost, err_count, bit_count
    );
`else
    modport master (
        output mask, in_bit, in_valid, restart, clr_cnt,
        input  locked, err_pulse, lock_lost, err_count
    );

    modport slave (
        input  mask, in_bit, in_valid, restart, clr_cnt,
        output locked, err_pulse, lock_lost, err_count
    );
`endif
endinterface

// File: rtl/prbs_tap_xor.sv
// Fibonacci LFSR feedback: XOR-reduction of the register masked by the taps.
// Shared by the checker (bit prediction) and the generator (feedback bit).
module prbs_tap_xor #(
    parameter int N = 32
) (
    input  logic [N-1:0] mask,
    input  logic [N-1:0] state,
    output logic         tap_bit
);

    assign tap_bit = ^(mask & state);

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: hunts for N seed bits, verifies LOCK_CNT predicted bits, then
// free-runs its own LFSR while locked and counts line errors.
// Optional feature macro: PRBS_CHECKER_BITCNT_EN adds a 48-bit count of bits
// checked while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N           = 32,
    parameter int LOCK_CNT    = 64,
    parameter int LOSS_WIN    = 256,
    parameter int LOSS_THRESH = 8
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int BW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int TW = $clog2(LOSS_THRESH + 1);

    localparam logic [BW-1:0] BIT_LAST    = BW'(N - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(LOSS_WIN - 1);
    localparam logic [TW-1:0] THRESH_LAST = TW'(LOSS_THRESH - 1);

    if (N < 4 || N > 64) begin : g_bad_n
        $error("prbs_checker: N must be within 4..64");
    end

    prbs_state_e          state;
    logic [N-1:0]         sr;
    logic [N-1:0]         mask_r;
    logic [N-1:0]         sr_shift;
    logic [BW-1:0]        bit_cnt;
    logic [MW-1:0]        match_cnt;
    logic [WW-1:0]        win_cnt;
    logic [TW-1:0]        win_err;
    logic                 predicted;
    logic                 miss;
    logic                 err_hit;
    logic                 loss_hit;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic                 lock_lost_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    prbs_tap_xor #(.N(N)) u_tap_xor (
        .mask    (mask_r),
        .state   (sr),
        .tap_bit (predicted)
    );

    // Decode this cycle's bit: comparison against prediction and error events.
    // NOTE: every signal gets a value before any condition, so no latch is inferred.
    always_comb begin
        sr_shift = {sr[N-2:0], bus.in_bit};
        miss     = bus.in_bit ^ predicted;
        err_hit  = 1'b0;
        loss_hit = 1'b0;
        if (bus.in_valid && !bus.restart && state == LOCKED && miss) begin
            err_hit  = 1'b1;
            loss_hit = (win_err == THRESH_LAST);
        end
    end

    // Lock FSM with its shift register, counters and registered status outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            sr          <= '0;
            mask_r      <= '0;
            bit_cnt     <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            err_pulse_q <= err_hit;
            lock_lost_q <= 1'b0;

            // The tap mask follows the input only while hunting.
            if (state == HUNT) begin
                mask_r <= bus.mask;
            end

            if (bus.restart) begin
                state     <= HUNT;
                locked_q  <= 1'b0;
                sr        <= '0;
                bit_cnt   <= '0;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
            end else if (bus.in_valid) begin
                unique case (state)
                    HUNT: begin
                        sr <= sr_shift;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            // An all-zero seed would lock onto a dead stream.
                            if (sr_shift != '0) begin
                                state <= VERIFY;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end

                    VERIFY: begin
                        sr <= sr_shift;
                        if (miss) begin
                            state     <= HUNT;
                            match_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state     <= LOCKED;
                            locked_q  <= 1'b1;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end

                    LOCKED: begin
                        // Free-run on the prediction so a line error is not
                        // fed back into the register and counted again.
                        sr <= {sr[N-2:0], predicted};
                        if (loss_hit) begin
                            state       <= HUNT;
                            locked_q    <= 1'b0;
                            lock_lost_q <= 1'b1;
                            win_cnt     <= '0;
                            win_err     <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err + TW'(err_hit);
                        end
                    end

                    default: begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (bus.clr_cnt) begin
            err_count_q <= ERR_CNT_W'(err_hit);
        end else if (err_hit) begin
            err_count_q <= err_sat_inc(err_count_q);
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.err_count = err_count_q;

`ifdef PRBS_CHECKER_BITCNT_EN
    logic [BIT_CNT_W-1:0] bit_count_q;

    // Saturating count of valid bits checked while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count_q <= '0;
        end else if (bus.clr_cnt) begin
            bit_count_q <= '0;
        end else if (bus.in_valid && !bus.restart && state == LOCKED && bit_count_q != '1) begin
            bit_count_q <= bit_count_q + BIT_CNT_W'(1);
        end
    end

    assign bus.bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: the stimulus process feeds an LFSR stream
// (with deliberate bit inversions) and queues the expected outputs from a
// bit-history reference model; a monitor pops and compares after each edge.
module tb_prbs_checker;

    localparam int N           = 32;
    localparam int LOCK_CNT    = 64;
    localparam int LOSS_WIN    = 256;
    localparam int LOSS_THRESH = 8;

    typedef struct {
        bit          locked;
        bit          err_pulse;
        bit          lock_lost;
        logic [31:0] err_count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prbs_checker_if #(.N(N)) bus ();

    prbs_checker #(
        .N           (N),
        .LOCK_CNT    (LOCK_CNT),
        .LOSS_WIN    (LOSS_WIN),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        exp_q[$];

    logic [N-1:0] mask_v    = 32'h80200003;
    logic [N-1:0] gen_state = 32'h1;

    // Reference model: phase 0 = hunting, 1 = verifying, 2 = locked.
    int          m_phase = 0;
    int          m_hunt  = 0;
    int          m_match = 0;
    int          m_wcnt  = 0;
    int          m_werr  = 0;
    logic [31:0] m_errs  = 0;
    bit          hist[$];   // hist[0] is the most recent bit

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit gen_next();
        bit fb;
        fb = ^(mask_v & gen_state);
        gen_state = {gen_state[N-2:0], fb};
        return fb;
    endfunction

    function automatic bit model_predict();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N && i < hist.size(); i++) p ^= mask_v[i] & hist[i];
        return p;
    endfunction

    function automatic bit hist_nonzero();
        for (int i = 0; i < hist.size(); i++) if (hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hunt = 0; m_match = 0; m_wcnt = 0; m_werr = 0; m_errs = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit v, input bit b, input bit rs, input bit clr, output exp_t e);
        bit err, lost, pred;
        err  = 1'b0;
        lost = 1'b0;
        pred = model_predict();
        if (rs) begin
            m_phase = 0; m_hunt = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
            hist.delete();
        end else if (v) begin
            case (m_phase)
                0: begin
                    hist.push_front(b);
                    m_hunt++;
                    if (m_hunt == N) begin
                        m_hunt = 0;
                        if (hist_nonzero()) m_phase = 1;
                    end
                end
                1: begin
                    hist.push_front(b);
                    if (b != pred) begin
                        m_phase = 0; m_match = 0;
                    end else if (++m_match == LOCK_CNT) begin
                        m_phase = 2; m_match = 0; m_wcnt = 0; m_werr = 0;
                    end
                end
                default: begin
                    err = (b != pred);
                    hist.push_front(pred);
                    m_wcnt++;
                    if (err) m_werr++;
                    if (m_werr == LOSS_THRESH) begin
                        lost = 1'b1; m_phase = 0; m_hunt = 0; m_wcnt = 0; m_werr = 0;
                    end else if (m_wcnt == LOSS_WIN) begin
                        m_wcnt = 0; m_werr = 0;
                    end
                end
            endcase
            while (hist.size() > N) void'(hist.pop_back());
        end
        if (clr) m_errs = err ? 32'd1 : 32'd0;
        else if (err && m_errs != 32'hFFFF_FFFF) m_errs++;
        e.locked    = (m_phase == 2);
        e.err_pulse = err;
        e.lock_lost = lost;
        e.err_count = m_errs;
    endtask

    // Apply one cycle of stimulus at the falling edge and queue its expectation.
    task automatic step_bit(input bit v, input bit b, input bit rs, input bit clr);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.restart  = rs;
        bus.clr_cnt  = clr;
        model_step(v, b, rs, clr, e);
        exp_q.push_back(e);
    endtask

    // Generator-driven cycle; the stream only advances on valid, non-restart cycles.
    task automatic step(input bit v, input bit flip, input bit rs, input bit clr);
        bit b;
        if (v && !rs) b = gen_next() ^ flip;
        else          b = 1'($urandom);
        step_bit(v, b, rs, clr);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: compare the DUT against each queued expectation after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("locked",    bus.locked,    e.locked);
                check("err_pulse", bus.err_pulse, e.err_pulse);
                check("lock_lost", bus.lock_lost, e.lock_lost);
                check("err_count", bus.err_count, e.err_count);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mask     = mask_v;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.clr_cnt  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        check("rst_locked",    bus.locked,    0);
        check("rst_err_pulse", bus.err_pulse, 0);
        check("rst_lock_lost", bus.lock_lost, 0);
        check("rst_err_count", bus.err_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean stream from seed 1: lock exactly after N + LOCK_CNT bits.
        repeat (N + LOCK_CNT - 1) step(1, 0, 0, 0);
        settle();
        check("lock_early", bus.locked, 0);
        step(1, 0, 0, 0);
        settle();
        check("lock_rise", bus.locked, 1);
        check("lock_errs", bus.err_count, 0);
        repeat (50) step(1, 0, 0, 0);

        // Eight inversions inside one window force loss of lock.
        for (int k = 0; k < LOSS_THRESH; k++) begin
            repeat (9) step(1, 0, 0, 0);
            step(1, 1, 0, 0);
        end
        settle();
        check("loss_pulse",  bus.lock_lost, 1);
        check("loss_locked", bus.locked,    0);
        check("loss_errs",   bus.err_count, 8);
        repeat (N + LOCK_CNT - 1) step(1, 0, 0, 0);
        settle();
        check("relock_early", bus.locked, 0);
        step(1, 0, 0, 0);
        settle();
        check("relock", bus.locked, 1);

        // Single inversion while locked.
        step(1, 0, 0, 1);
        settle();
        check("clr_clean", bus.err_count, 0);
        step(1, 1, 0, 0);
        settle();
        check("single_pulse",  bus.err_pulse, 1);
        check("single_errs",   bus.err_count, 1);
        check("single_locked", bus.locked,    1);
        step(1, 0, 0, 0);
        settle();
        check("single_pulse_end", bus.err_pulse, 0);

        // Clear coinciding with an error.
        for (int k = 0; k < 4; k++) begin
            repeat (5) step(1, 0, 0, 0);
            step(1, 1, 0, 0);
        end
        settle();
        check("errs_five", bus.err_count, 5);
        step(1, 1, 0, 1);
        settle();
        check("clr_with_err", bus.err_count, 1);
        check("clr_locked",   bus.locked,    1);

        // Asynchronous reset mid-lock, between clock edges.
        #1;
        rst = 1'b1;
        #1;
        check("arst_locked",    bus.locked,    0);
        check("arst_err_pulse", bus.err_pulse, 0);
        check("arst_lock_lost", bus.lock_lost, 0);
        check("arst_err_count", bus.err_count, 0);
        model_reset();
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.clr_cnt  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // All-zero stream never leaves the hunt.
        repeat (200) step_bit(1, 0, 0, 0);
        settle();
        check("zero_locked", bus.locked,    0);
        check("zero_errs",   bus.err_count, 0);

        // Restart, then a clean stream with in_valid toggling.
        step(1, 0, 1, 0);
        for (int k = 0; k < N + LOCK_CNT - 1; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        settle();
        check("toggle_early", bus.locked, 0);
        step(1, 0, 0, 0);
        settle();
        check("toggle_lock", bus.locked, 1);

        // Randomised traffic: gaps, occasional errors, clears and restarts.
        for (int k = 0; k < 3000; k++) begin
            bit v, flip, rs, clr;
            v    = ($urandom_range(3) != 0);
            flip = ($urandom_range(99) == 0);
            rs   = ($urandom_range(499) == 0);
            clr  = ($urandom_range(299) == 0);
            step(v, flip, rs, clr);
        end

        settle();
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.clr_cnt  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 32: LFSR width; the SHALL-support range is 4..64.
REQ-002 Parameter LOCK_CNT, default 64: consecutive matching bits needed to declare lock.
REQ-003 Parameter LOSS_WIN, default 256: length in valid bits of the loss-of-lock observation window.
REQ-004 Parameter LOSS_THRESH, default 8: errors within one window that force loss of lock.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 mask  input  N  feedback tap mask, same Fibonacci convention as the team's lfsr generator.
REQ-008 in_bit  input  1  received serial bit, equal to the generator's newly inserted bit (dff[0] after each shift).
REQ-009 in_valid  input  1  in_bit is qualified this cycle; no action when low.
REQ-010 restart  input  1  synchronous one-cycle request to return to HUNT.
REQ-011 clr_cnt  input  1  synchronous clear of err_count.
REQ-012 locked  output  1  high while the FSM is in LOCKED.
REQ-013 err_pulse  output  1  one-cycle pulse for each mismatched valid bit in LOCKED.
REQ-014 lock_lost  output  1  one-cycle pulse on a LOCKED->HUNT transition caused by errors.
REQ-015 err_count  output  32  saturating count of errors seen while LOCKED.

Function
REQ-016 Predicted bit = XOR over i of (mask_r[i] & sr[i]); sr shifts as {sr[N-2:0], b} on each valid bit.
REQ-017 FSM states and behaviour on each valid bit:
- HUNT: shift in in_bit; bit counter counts to N.
- VERIFY: shift in in_bit.
- LOCKED: shift in the predicted bit (free-running), so each line error counts once.
REQ-018 Transitions:
- HUNT->VERIFY after N valid bits, provided sr is nonzero; an all-zero sr restarts the N-bit count and stays in HUNT.
- VERIFY: a mismatch returns to HUNT; LOCK_CNT consecutive matches move to LOCKED.
- LOCKED->HUNT when window errors reach LOSS_THRESH; lock_lost pulses that cycle.
REQ-019 LOCKED window: the window counter counts valid bits to LOSS_WIN, then clears the window error count and wraps.
REQ-020 err_pulse and err_count update in the cycle after the offending valid bit (1-cycle latency); mismatches outside LOCKED are not counted.
REQ-021 err_count saturates at 32'hFFFFFFFF.
REQ-022 If clr_cnt and an error occur in the same cycle, err_count becomes 1.
REQ-023 mask_r is sampled from mask on every cycle in HUNT and held in VERIFY and LOCKED.
REQ-024 restart has priority over all transitions: next state HUNT, counters and sr cleared, err_count kept, no lock_lost pulse.

Reset
REQ-025 rst asserted, at any time including mid-lock: state HUNT and sr, mask_r and all counters zero.
REQ-026 Output values while in reset: locked=0, err_pulse=0, lock_lost=0, err_count=0.

Configuration
REQ-027 Macro PRBS_CHECKER_BITCNT_EN defined: adds output bit_count (48 bits), a saturating count of valid bits checked in LOCKED, cleared by rst and clr_cnt.
REQ-028 Macro PRBS_CHECKER_BITCNT_EN undefined: no bit_count port and no related logic.

Structure
REQ-029 The shared package/include prbs_pkg holds the FSM state encodings (HUNT=2'd0, VERIFY=2'd1, LOCKED=2'd2) and the err_count width constant.
REQ-030 The sub-module prbs_tap_xor (N-bit mask AND sr, XOR-reduced) computes the predicted bit and is reusable by the generator.

Verification
REQ-031 N=32, mask 32'h80200003, lfsr seeded 32'h1, in_valid=1 continuously -> locked rises N+LOCK_CNT+1 cycles after rst release; err_count stays 0.
REQ-032 Locked, single bit of stream inverted -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-033 Locked, 8 inverted bits within 256 -> lock_lost pulse, locked=0, err_count=8, relock after a further 96 clean bits.
REQ-034 All-zero stream for 200 cycles -> stays in HUNT, locked=0, err_count=0.
REQ-035 Locked with err_count=5, clr_cnt asserted with a simultaneous error -> err_count=1; rst asserted mid-lock -> all outputs 0 immediately, asynchronously.
REQ-036 in_valid toggling 1/0 with a clean stream -> lock after 96 valid bits; idle cycles neither shift state nor advance counters.
